// File: rtl/offchip_pkg.sv
// Shared types and constants for the off-chip link arbiter and lane-buffer controller.
package offchip_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Downstream lane buffer: 8 entries of 32 bits each.
  localparam int CREDITS          = 8;
  // A 64-bit beat occupies two 32-bit lane entries.
  localparam int ENTRIES_PER_BEAT = 2;
  // The reader hands space back in chunks of this many entries.
  localparam int CRD_RET_QUANTUM  = 4;
  // Width of the free-entry counter, able to hold 0..CREDITS.
  localparam int CRD_W            = clog2(CREDITS + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/offchip_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by the pointer,
// priority-encode the lowest set bit, then rotate the index back.
module offchip_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    offset;

  // Rotate so the pointer position becomes bit 0, then pick the first requester.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[N_REQ-1:0];
    offset  = '0;
    any     = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = ID_W'(i);
        any    = 1'b1;
      end
    end
    grant_idx = ID_W'((int'(offset) + int'(ptr)) % N_REQ);
    grant     = any ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/offchip_link_arbiter.sv
// Round-robin, credit-gated arbiter sharing one 64-bit off-chip link
// between N_REQ requesters ahead of the lane-split buffer.
module offchip_link_arbiter
  import offchip_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    link_valid,
  output logic [DATA_W-1:0]       link_data,
  output logic [ID_W-1:0]         link_id,
  input  logic                    link_ready,
  input  logic                    crd_ret,
  output logic [CRD_W-1:0]        credits,
  output logic                    err_crd_ovf
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;
  logic             take;
  logic             debit;
  logic [CRD_W:0]   credit_sum;

  offchip_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, grant pulse and debit; a grant needs room for a whole beat.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    take       = 1'b0;
    debit      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && arb_any && (credits >= CRD_W'(ENTRIES_PER_BEAT))) begin
          req_ready  = arb_grant;
          take       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (link_ready) begin
          debit      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign link_valid = (state == SEND);

  // Payload register: captured on grant, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_data <= '0;
      link_id   <= '0;
    end else if (take) begin
      link_data <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
      link_id   <= arb_idx;
    end
  end

  // Round-robin pointer advances past the owner once its beat is delivered.
  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= '0;
    else if (debit) rr_ptr <= ID_W'((int'(link_id) + 1) % N_REQ);
  end

  // One extra bit so a return on a full counter is visible as overflow.
  always_comb begin
    credit_sum = {1'b0, credits}
               - (debit   ? (CRD_W+1)'(ENTRIES_PER_BEAT) : '0)
               + (crd_ret ? (CRD_W+1)'(CRD_RET_QUANTUM)  : '0);
  end

  // Credit counter with clamp and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits     <= CRD_W'(CREDITS);
      err_crd_ovf <= 1'b0;
    end else if (credit_sum > (CRD_W+1)'(CREDITS)) begin
      credits     <= CRD_W'(CREDITS);
      err_crd_ovf <= 1'b1;
    end else begin
      credits     <= credit_sum[CRD_W-1:0];
    end
  end

endmodule
